posit_mac_feeder: RTL
=====================

Name: posit_mac_feeder

Overview:
- Operand sequencer sitting directly upstream of the posit MAC.
- Accepts (weight, data) posit pairs over a valid/ready stream into a two-bank ping-pong buffer of K pairs per bank.
- Issues each full bank to the MAC as one contiguous K-cycle burst, then holds off until the MAC reports its result, plus a guard gap so the MAC's valid history drains to zero and its accumulator clears before the next dot product.
- Flags a timeout if the MAC never answers.

Parameters:
- WIDTH, 8, posit bitwidth of each operand.
- K, 4, pairs per dot product; must equal the MAC's K; K >= 1.
- WK, $clog2(K)+1, width of pair counters (holds 0..K).
- GAP, 2, idle cycles forced on mac_vld_i after mac_vld_o before the next burst; GAP >= 1.
- TIMEOUT, 64, max cycles from last burst beat to mac_vld_o; TIMEOUT > 16.
- WT, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rstn, input, 1, asynchronous active-low reset.
- in_vld, input, 1, upstream pair valid.
- in_rdy, output, 1, feeder can accept a pair this cycle.
- w_in, input, WIDTH, weight posit.
- d_in, input, WIDTH, data posit.
- mac_vld_i, output, 1, operand valid to MAC (drives MAC vld_i).
- mac_win, output, WIDTH, weight to MAC, registered.
- mac_din, output, WIDTH, data to MAC, registered.
- mac_vld_o, input, 1, MAC result-valid pulse.
- busy, output, 1, a burst is in flight (BURST, WAIT or GAP).
- err_timeout, output, 1, sticky; set when TIMEOUT expires.
- err_clr, input, 1, synchronous clear of err_timeout.

Behaviour:
- Reset (async, rstn=0): every output register cleared; in_rdy=0 while rstn=0; state=IDLE.
  - Both banks empty; fill bank=0, issue bank=0; all counters 0.
  - Buffer contents are don't-care.
- Fill side:
  - Transfer occurs when in_vld & in_rdy.
  - in_rdy=1 when the fill bank is not full.
  - Each transfer writes {w_in, d_in} at fill index, then increments the index.
  - At index K the bank is marked full and filling switches to the other bank, but only if that bank is empty; otherwise in_rdy=0 until it frees.
- Issue FSM, states IDLE, BURST, WAIT, GAP:
  - IDLE: if the issue bank is full, go to BURST next cycle; rd index=0.
  - BURST: for exactly K consecutive cycles, mac_vld_i=1 and mac_win/mac_din = bank[issue][rd]; rd increments each cycle.
    - No bubbles are permitted, since the MAC counts K contiguous beats.
    - After beat K-1: mark the issue bank empty, toggle the issue bank, go to WAIT.
  - WAIT: mac_vld_i=0, timeout counter increments.
    - On mac_vld_o=1: go to GAP.
    - If the counter reaches TIMEOUT: set err_timeout and go to GAP.
  - GAP: hold GAP cycles with mac_vld_i=0, then go to IDLE.
- Output timing:
  - Outputs are registered; the first burst beat appears 2 cycles after the K-th transfer into an empty feeder (IDLE sees full, then BURST).
  - Earliest next burst is GAP+1 cycles after mac_vld_o.
- mac_win/mac_din hold their last values when mac_vld_i=0.
- Simultaneous events:
  - A bank freeing in the last BURST cycle and a fill wrap in the same cycle: the fill side sees the bank empty in the next cycle (no same-cycle bypass).
  - A fill write and a burst read never target the same bank.
  - err_clr together with a timeout expiry: the set wins.
- A mac_vld_o arriving outside WAIT is ignored.
- busy = (state != IDLE).
- Reset mid-burst discards all buffered pairs and forces mac_vld_i=0 immediately (async).

Test Plan:
- Single dot product, K=4: push pairs (0x40,0x40)x4 with in_vld held high.
  - Required: in_rdy stays 1, then 4 contiguous mac_vld_i beats carrying 0x40/0x40 starting 2 cycles after the 4th transfer.
  - Model mac_vld_o 14 cycles after the last beat; busy drops GAP+1 cycles after it.
- Back-to-back: push 12 pairs continuously.
  - Required: 8 accepted without stall, then in_rdy=0 until the first burst completes.
  - Bursts 2 and 3 each start exactly GAP+1 cycles after the previous mac_vld_o; operand order is preserved (check distinct values 0x01..0x0C).
- Bubbled input: in_vld toggles 1/0.
  - Required: the burst is still K contiguous beats; no mac_vld_i until the bank is full.
- Timeout: never assert mac_vld_o.
  - Required: err_timeout=1 exactly TIMEOUT cycles after the last beat, FSM recovers to IDLE and the next bank issues.
  - Then err_clr=1 -> err_timeout=0 next cycle.
- Stray mac_vld_o during BURST: ignored; the FSM still waits for a mac_vld_o in WAIT.
- Reset asserted mid-burst (beat 2 of 4): mac_vld_i=0 immediately; after release, in_rdy=1, busy=0, and no residual beats are emitted.

Source files
------------

// File: rtl/posit_mac_feeder.sv
// Operand sequencer ahead of the posit MAC: ping-pong buffers (weight, data) pairs
// and issues each full bank as one gap-free K-beat burst, then waits for the MAC result.
module posit_mac_feeder #(
  parameter int WIDTH   = 8,
  parameter int K       = 4,
  parameter int WK      = $clog2(K) + 1,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64,
  parameter int WT      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] w_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             mac_vld_i,
  output logic [WIDTH-1:0] mac_win,
  output logic [WIDTH-1:0] mac_din,
  input  logic             mac_vld_o,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int WA = (K > 1) ? $clog2(K) : 1;
  localparam int WG = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_WAIT, S_GAP} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   pairMem [2][K];
  logic [1:0]           full_q, full_d;
  logic                 fillBank_q, fillBank_d, otherBank, issueBank_q;
  logic [WK-1:0]        fillIdx_q, fillIdx_d, rdIdx_q;
  logic [WT-1:0]        tmoCnt_q;
  logic [WG-1:0]        gapCnt_q;
  logic                 macVld_q, err_q;
  logic [WIDTH-1:0]     macWin_q, macDin_q;
  logic                 fillFire, fillWrap, gapDone, startBurst, lastBeat;
  logic [2*WIDTH-1:0]   rdWord;

  always_comb begin
    otherBank  = ~fillBank_q;
    in_rdy     = rstn & ~full_q[fillBank_q];
    fillFire   = in_vld & in_rdy;
    fillWrap   = fillFire && (fillIdx_q == WK'(K - 1));
    gapDone    = (state_q == S_GAP) && (gapCnt_q == WG'(GAP - 1));
    // A burst may launch straight out of the last guard cycle so the MAC sees exactly GAP idle cycles.
    startBurst = full_q[issueBank_q] && ((state_q == S_IDLE) || gapDone);
    lastBeat   = ((state_q == S_BURST) && (rdIdx_q == WK'(K - 1))) || (startBurst && (K == 1));
    rdWord     = pairMem[issueBank_q][startBurst ? WA'(0) : rdIdx_q[WA-1:0]];
  end

  always_comb begin
    fillIdx_d  = fillIdx_q;
    fillBank_d = fillBank_q;
    full_d     = full_q;
    if (fillFire) begin
      fillIdx_d = fillWrap ? '0 : fillIdx_q + 1'b1;
    end
    // Bank switch uses registered flags only; a bank freed this cycle is seen next cycle.
    if (fillWrap) begin
      full_d[fillBank_q] = 1'b1;
      if (!full_q[otherBank]) begin
        fillBank_d = otherBank;
      end
    end else if (full_q[fillBank_q] && !full_q[otherBank]) begin
      fillBank_d = otherBank;
    end
    if (lastBeat) begin
      full_d[issueBank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q     <= '0;
      fillBank_q <= 1'b0;
      fillIdx_q  <= '0;
    end else begin
      full_q     <= full_d;
      fillBank_q <= fillBank_d;
      fillIdx_q  <= fillIdx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fillFire) begin
      pairMem[fillBank_q][fillIdx_q[WA-1:0]] <= {w_in, d_in};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      issueBank_q <= 1'b0;
      rdIdx_q     <= '0;
      tmoCnt_q    <= '0;
      gapCnt_q    <= '0;
      macVld_q    <= 1'b0;
      macWin_q    <= '0;
      macDin_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      macVld_q <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
      end
      if (startBurst || (state_q == S_BURST)) begin
        macVld_q             <= 1'b1;
        {macWin_q, macDin_q} <= rdWord;
      end
      if (lastBeat) begin
        issueBank_q <= ~issueBank_q;
      end
      case (state_q)
        S_IDLE: begin
          rdIdx_q <= '0;
          if (startBurst) begin
            rdIdx_q  <= WK'(1);
            tmoCnt_q <= '0;
            state_q  <= (K == 1) ? S_WAIT : S_BURST;
          end
        end
        S_BURST: begin
          rdIdx_q <= rdIdx_q + 1'b1;
          if (lastBeat) begin
            rdIdx_q  <= '0;
            tmoCnt_q <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mac_vld_o) begin
            gapCnt_q <= '0;
            state_q  <= S_GAP;
          end else if (tmoCnt_q == WT'(TIMEOUT - 1)) begin
            err_q    <= 1'b1;
            gapCnt_q <= '0;
            state_q  <= S_GAP;
          end else begin
            tmoCnt_q <= tmoCnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gapDone) begin
            if (startBurst) begin
              rdIdx_q  <= WK'(1);
              tmoCnt_q <= '0;
              state_q  <= (K == 1) ? S_WAIT : S_BURST;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            gapCnt_q <= gapCnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mac_vld_i   = macVld_q;
  assign mac_win     = macWin_q;
  assign mac_din     = macDin_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule
